// File: rtl/ti_pkg.sv
// Shared TI definitions: wrapper state encoding and default drain timeout.
// Reused by the TI controller and the other wrapper flavours.
package ti_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_STOPPED = 2'b10
    } ti_state_e;

    localparam int TI_STOP_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/ti_skid_fifo2.sv
// Two-entry {data,last} FIFO. A push becomes visible at the head on the next
// cycle; push and pop in the same cycle sustain one beat per cycle.
module ti_skid_fifo2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_last_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH:0] mem_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_data_o = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign head_last_o = mem_q[rd_ptr_q][DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/ti_stream_wrapper.sv
// TI wrapper for one stream channel: acknowledges stop_req only at a packet
// boundary, with a bounded drain and discard of a truncated packet's tail.
module ti_stream_wrapper
    import ti_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STOP_TIMEOUT = TI_STOP_TIMEOUT_DEFAULT,
    parameter int CNT_WIDTH    = (STOP_TIMEOUT > 0) ? $clog2(STOP_TIMEOUT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic                  stop_req,
    output logic                  stop_ack,
    output logic                  drain_timeout
);

    localparam bit                   TIMEOUT_EN  = (STOP_TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(STOP_TIMEOUT);

    ti_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 in_pkt_q, in_pkt_d;
    logic                 drop_q, drop_d;
    logic                 timeout_q, timeout_d;
    logic                 ack_q, ack_d;

    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  run_stop;
    logic                  m_valid;
    logic                  m_xfer;
    logic                  drop_pop;
    logic                  timeout_hit;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    ti_skid_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (s_tvalid & ~fifo_full),
        .push_data_i (s_tdata),
        .push_last_i (s_tlast),
        .pop_i       (m_xfer | drop_pop),
        .head_data_o (head_data),
        .head_last_o (head_last),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // An idle RUN cycle that sees stop_req must not hand out a beat of the next packet.
    assign run_stop    = (state_q == ST_RUN) && stop_req && !in_pkt_q;
    assign cnt_inc     = cnt_q + CNT_WIDTH'(1);
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        case (state_q)
            ST_RUN:   m_valid = !fifo_empty && !drop_q && !run_stop;
            ST_DRAIN: m_valid = !fifo_empty;
            default:  m_valid = 1'b0;
        endcase
    end

    assign m_xfer   = m_valid && m_tready;
    assign drop_pop = (state_q == ST_RUN) && drop_q && !fifo_empty && !run_stop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_pkt_d  = in_pkt_q;
        drop_d    = drop_q;
        timeout_d = timeout_q;
        if (m_xfer) begin
            in_pkt_d = !head_last;
        end
        if (drop_pop && head_last) begin
            drop_d = 1'b0;
        end
        case (state_q)
            ST_RUN: begin
                // A packet ending in the very cycle of the request is already a boundary.
                if (stop_req) begin
                    if (!in_pkt_q || (m_xfer && head_last)) begin
                        state_d = ST_STOPPED;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_inc;
                if (!stop_req) begin
                    state_d = ST_RUN;
                end else if (m_xfer && head_last) begin
                    state_d = ST_STOPPED;
                end else if (timeout_hit) begin
                    state_d   = ST_STOPPED;
                    timeout_d = 1'b1;
                    drop_d    = 1'b1;
                    in_pkt_d  = 1'b0;
                end
            end
            ST_STOPPED: begin
                if (!stop_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        ack_d = (state_q == ST_STOPPED) && (state_d == ST_STOPPED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            in_pkt_q  <= 1'b0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_pkt_q  <= in_pkt_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
            ack_q     <= ack_d;
        end
    end

    assign s_tready      = !fifo_full;
    assign m_tvalid      = m_valid;
    assign m_tdata       = m_valid ? head_data : '0;
    assign m_tlast       = m_valid && head_last;
    assign stop_ack      = ack_q;
    assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_ti_stream_wrapper.sv
// Self-checking bench for ti_stream_wrapper: behavioural packet-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ti_stream_wrapper;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          stop_req;
    logic          stop_ack;
    logic          drain_timeout;

    always #5 clk = ~clk;

    ti_stream_wrapper #(
        .DATA_WIDTH   (DW),
        .STOP_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .stop_req      (stop_req),
        .stop_ack      (stop_ack),
        .drain_timeout (drain_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int rdy_pct = 100;
    int vld_pct = 100;

    logic [DW:0] src_q[$];
    logic [DW:0] exp_q[$];
    logic [DW:0] got_q[$];
    int xfer_cnt = 0;
    int first_push_cyc = -1;
    int first_xfer_cyc = -1;
    int last_xfer_cyc = -1;

    // Model: stopped / draining / resuming-with-discard, tracked as plain flags.
    bit m_stopped, m_draining, m_in_pkt, m_drop, m_to, m_ack;
    int m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic add_pkt(input int len, input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            src_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, rnd ? DW'($urandom) : base + DW'(i)});
        end
    endtask

    // Producer and consumer-ready driver.
    initial begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
                s_tvalid = 1'b1;
                {s_tlast, s_tdata} = src_q[0];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = '0;
                s_tlast  = 1'b0;
            end
            m_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Every-cycle compare against the model, then advance the model.
    initial begin
        bit          e_rdy, e_head, e_vld, xfer, dpop, running, was_stopped, old_in_pkt;
        logic [DW:0] head;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_stopped  = 1'b0;
                m_draining = 1'b0;
                m_in_pkt   = 1'b0;
                m_drop     = 1'b0;
                m_to       = 1'b0;
                m_ack      = 1'b0;
                m_cnt      = 0;
            end else begin
                e_rdy  = exp_q.size() < 2;
                e_head = exp_q.size() > 0;
                head   = e_head ? exp_q[0] : '0;
                if (m_stopped) e_vld = 1'b0;
                else if (m_draining) e_vld = e_head;
                else e_vld = e_head && !m_drop && !(stop_req && !m_in_pkt);
                if (chk_en) begin
                    chk("s_tready", s_tready, e_rdy);
                    chk("m_tvalid", m_tvalid, e_vld);
                    if (e_vld) begin
                        chk("m_tdata", m_tdata, head[DW-1:0]);
                        chk("m_tlast", m_tlast, head[DW]);
                    end
                    chk("stop_ack", stop_ack, m_ack);
                    chk("drain_timeout", drain_timeout, m_to);
                end
                if (s_tvalid && s_tready) begin
                    void'(src_q.pop_front());
                    if (first_push_cyc < 0) first_push_cyc = cyc;
                end
                if (m_tvalid && m_tready) begin
                    got_q.push_back({m_tlast, m_tdata});
                    xfer_cnt++;
                    if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                end
                xfer        = e_vld && m_tready;
                running     = !m_stopped && !m_draining;
                dpop        = running && m_drop && e_head && !stop_req;
                was_stopped = m_stopped;
                old_in_pkt  = m_in_pkt;
                if (xfer || dpop) void'(exp_q.pop_front());
                if (xfer) m_in_pkt = !head[DW];
                if (dpop && head[DW]) m_drop = 1'b0;
                if (running) begin
                    if (stop_req) begin
                        if (!old_in_pkt || (xfer && head[DW])) m_stopped = 1'b1;
                        else begin
                            m_draining = 1'b1;
                            m_cnt      = 0;
                        end
                    end
                end else if (m_draining) begin
                    m_cnt++;
                    if (!stop_req) m_draining = 1'b0;
                    else if (xfer && head[DW]) begin
                        m_draining = 1'b0;
                        m_stopped  = 1'b1;
                    end else if (TO != 0 && m_cnt == TO) begin
                        m_draining = 1'b0;
                        m_stopped  = 1'b1;
                        m_to       = 1'b1;
                        m_drop     = 1'b1;
                        m_in_pkt   = 1'b0;
                    end
                end else if (!stop_req) begin
                    m_stopped = 1'b0;
                end
                m_ack = was_stopped && m_stopped;
                if (s_tvalid && e_rdy) exp_q.push_back({s_tlast, s_tdata});
            end
        end
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int          n;
        logic [DW:0] tp_ref[100];
        logic [DW:0] lit;
        stop_req = 1'b0;
        rst      = 1'b1;
        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset s_tready", s_tready, 1);
        chk("reset m_tvalid", m_tvalid, 0);
        chk("reset m_tdata", m_tdata, 0);
        chk("reset stop_ack", stop_ack, 0);
        chk("reset drain_timeout", drain_timeout, 0);

        // Idle stop: ack two cycles after the request, one cycle after release.
        repeat (5) tick();
        stop_req = 1'b1;
        #1;
        chk("idle m_tvalid", m_tvalid, 0);
        chk("idle ack t0", stop_ack, 0);
        tick();
        chk("idle ack t1", stop_ack, 0);
        tick();
        chk("idle ack t2", stop_ack, 1);
        repeat (8) tick();
        stop_req = 1'b0;
        #1;
        chk("idle ack at release", stop_ack, 1);
        tick();
        chk("idle ack after release", stop_ack, 0);
        repeat (3) tick();

        // Mid-packet stop.
        got_q.delete();
        add_pkt(8, 32'h100, 1'b0);
        add_pkt(4, 32'h200, 1'b0);
        for (n = 0; n < 50 && got_q.size() < 3; n++) tick();
        chk("mid wait beat3", got_q.size() >= 3, 1);
        stop_req = 1'b1;
        for (n = 0; n < 100 && !stop_ack; n++) tick();
        chk("mid wait ack", stop_ack, 1);
        chk("mid beats at ack", got_q.size(), 8);
        lit = {1'b1, 32'h107};
        chk("mid last beat", got_q[got_q.size() - 1], lit);
        repeat (4) tick();
        #1;
        chk("mid held s_tready", s_tready, 0);
        chk("mid held m_tvalid", m_tvalid, 0);
        chk("mid held beats", got_q.size(), 8);
        stop_req = 1'b0;
        for (n = 0; n < 50 && got_q.size() < 12; n++) tick();
        chk("mid resume count", got_q.size(), 12);
        lit = {1'b0, 32'h200};
        chk("mid resume first", got_q[8], lit);
        lit = {1'b1, 32'h203};
        chk("mid resume last", got_q[11], lit);
        repeat (3) tick();

        // Back-pressured drain hits the timeout; tail of the packet is discarded.
        got_q.delete();
        add_pkt(6, 32'h300, 1'b0);
        add_pkt(3, 32'h400, 1'b0);
        for (n = 0; n < 50 && got_q.size() < 2; n++) tick();
        chk("bp wait beat2", got_q.size() >= 2, 1);
        stop_req = 1'b1;
        rdy_pct  = 0;
        m_tready = 1'b0;
        for (n = 0; n < 40 && !stop_ack; n++) tick();
        chk("bp cycles to ack", n, 18);
        chk("bp drain_timeout", drain_timeout, 1);
        chk("bp beats at ack", got_q.size(), 2);
        stop_req = 1'b0;
        rdy_pct  = 100;
        m_tready = 1'b1;
        for (n = 0; n < 60 && got_q.size() < 5; n++) tick();
        repeat (5) tick();
        chk("bp resume count", got_q.size(), 5);
        lit = {1'b0, 32'h400};
        chk("bp first after resume", got_q[2], lit);
        lit = {1'b1, 32'h402};
        chk("bp last after resume", got_q[4], lit);
        chk("bp timeout sticky", drain_timeout, 1);

        // tlast lands in the timeout cycle: normal stop.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("tie timeout cleared", drain_timeout, 0);
        got_q.delete();
        add_pkt(3, 32'h500, 1'b0);
        for (n = 0; n < 50 && got_q.size() < 1; n++) tick();
        chk("tie wait beat1", got_q.size() >= 1, 1);
        stop_req = 1'b1;
        rdy_pct  = 0;
        m_tready = 1'b0;
        repeat (15) tick();
        rdy_pct  = 100;
        m_tready = 1'b1;
        repeat (3) tick();
        #1;
        chk("tie stop_ack", stop_ack, 1);
        chk("tie drain_timeout", drain_timeout, 0);
        chk("tie beats", got_q.size(), 3);
        stop_req = 1'b0;
        repeat (3) tick();

        // Throughput: 100 beats back-to-back with one cycle of latency.
        got_q.delete();
        xfer_cnt       = 0;
        first_push_cyc = -1;
        first_xfer_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            tp_ref[i] = {(i == 99 || $urandom_range(5) == 0) ? 1'b1 : 1'b0, DW'($urandom)};
            src_q.push_back(tp_ref[i]);
        end
        for (n = 0; n < 300 && xfer_cnt < 100; n++) tick();
        chk("tp count", xfer_cnt, 100);
        chk("tp span", last_xfer_cyc - first_xfer_cyc, 99);
        chk("tp latency", first_xfer_cyc - first_push_cyc, 1);
        for (int i = 0; i < 100 && i < got_q.size(); i++) chk("tp beat", got_q[i], tp_ref[i]);
        repeat (3) tick();

        // Reset while stopped with a full buffer.
        stop_req = 1'b1;
        add_pkt(2, 32'h600, 1'b0);
        repeat (6) tick();
        #1;
        chk("rststop ack", stop_ack, 1);
        chk("rststop full", s_tready, 0);
        rst      = 1'b1;
        stop_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rststop s_tready", s_tready, 1);
        chk("rststop m_tvalid", m_tvalid, 0);
        chk("rststop stop_ack", stop_ack, 0);
        repeat (3) tick();

        // Randomized traffic, back-pressure, stop requests and resets.
        for (int seg = 0; seg < 200; seg++) begin
            while (src_q.size() < 12) add_pkt($urandom_range(1, 8), '0, 1'b1);
            case ($urandom_range(3))
                0: rdy_pct = 10;
                1: rdy_pct = 50;
                2: rdy_pct = 90;
                default: rdy_pct = 100;
            endcase
            vld_pct  = ($urandom_range(2) == 0) ? 40 : 100;
            stop_req = ($urandom_range(2) == 0);
            if ($urandom_range(60) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 30)) tick();
        end
        stop_req = 1'b0;
        rdy_pct  = 100;
        vld_pct  = 100;
        for (n = 0; n < 2000 && (src_q.size() > 0 || exp_q.size() > 0); n++) tick();
        chk("final drain", src_q.size() + exp_q.size(), 0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
